// File: rtl/pri_dac_pkg.sv
// PRI-triggered DAC playback: shared types and waveform tables.
// Tables map wave_code to sample RAM base address and length.
package pri_dac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    PLAY,
    FLUSH
  } state_t;

  localparam int TAPER_LEN = 64;
  localparam int TAPER_SH  = 6;

  function automatic logic code_ok(input logic [7:0] c);
    return (c >= 8'h01) && (c <= 8'h07);
  endfunction

  // Lengths are fixed by the waveform set.
  function automatic logic [15:0] wave_len(input logic [7:0] c);
    logic [15:0] r;
    case (c)
      8'h01:   r = 16'd500;
      8'h02:   r = 16'd1300;
      8'h03:   r = 16'd2000;
      8'h04:   r = 16'd24000;
      8'h05:   r = 16'd4000;
      8'h06:   r = 16'd4000;
      8'h07:   r = 16'd10000;
      default: r = 16'd0;
    endcase
    return r;
  endfunction

  // Code 04 ends exactly at the top of the 15-bit space.
  function automatic logic [15:0] wave_base(input logic [7:0] c);
    logic [15:0] r;
    case (c)
      8'h01:   r = 16'd0;
      8'h02:   r = 16'd512;
      8'h03:   r = 16'd2048;
      8'h04:   r = 16'd8768;
      8'h05:   r = 16'd4096;
      8'h06:   r = 16'd16384;
      8'h07:   r = 16'd20480;
      default: r = 16'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pri_dac_tx_taper.sv
// Linear ramp scaler for burst edges (used with DAC_TAPER_EN).
// out = (sample*k)>>>6, signed, registered; k is 1..64.
module dac_taper
  import pri_dac_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [6:0]        in_k,
  input  logic [DATA_W-1:0] in_i,
  input  logic [DATA_W-1:0] in_q,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_i,
  output logic [DATA_W-1:0] out_q
);

  localparam int PW = DATA_W + TAPER_SH;

  logic signed [PW-1:0] k_s;
  logic signed [PW-1:0] p_i;
  logic signed [PW-1:0] p_q;

  assign k_s = PW'($signed({1'b0, in_k}));
  assign p_i = PW'($signed(in_i)) * k_s;
  assign p_q = PW'($signed(in_q)) * k_s;

  // Scaled sample register; bits below the shift are dropped (floor).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
    end else begin
      out_valid <= in_valid;
      out_i     <= in_valid ? p_i[PW-1:TAPER_SH] : '0;
      out_q     <= in_valid ? p_q[PW-1:TAPER_SH] : '0;
    end
  end

endmodule

// File: rtl/pri_dac_tx.sv
// PRI-triggered I/Q waveform playback from sample RAM to DAC.
// Optional edge taper when DAC_TAPER_EN is defined.
module pri_dac_tx
  import pri_dac_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 15,
  parameter int PRE_DELAY = 120
) (
  input  logic                clk_100M,
  input  logic                rst_n,
  input  logic                PRI,
  input  logic [7:0]          wave_code,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_rd,
  input  logic [2*DATA_W-1:0] ram_data,
  output logic [DATA_W-1:0]   dac_i,
  output logic [DATA_W-1:0]   dac_q,
  output logic                dac_valid,
  output logic                tx_gate,
  output logic                busy,
  output logic                err_code,
  output logic                err_overrun
);

  localparam int CNT_W = $clog2(PRE_DELAY + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       n_q, n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        code_q, code_d;
  logic              pri_d;
  logic              pri_edge;
  logic              rd;
  logic              code_bad;
  logic              ovr;
  logic [15:0]       len;
  logic              rd_q;
  logic              s_valid;
  logic [DATA_W-1:0] s_i, s_q;

  assign pri_edge = PRI & ~pri_d;
  assign len      = wave_len(code_q);

  // State and burst counters.
  always_ff @(posedge clk_100M) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      n_q         <= '0;
      addr_q      <= '0;
      code_q      <= '0;
      pri_d       <= 1'b0;
      err_code    <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      addr_q      <= addr_d;
      code_q      <= code_d;
      pri_d       <= PRI;
      err_code    <= code_bad;
      err_overrun <= ovr;
    end
  end

  // Next state, read strobe and error flags.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    addr_d   = addr_q;
    code_d   = code_q;
    rd       = 1'b0;
    code_bad = 1'b0;
    ovr      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pri_edge) begin
          code_d = wave_code;
          if (code_ok(wave_code)) begin
            state_d = DELAY;
            cnt_d   = '0;
          end else begin
            code_bad = 1'b1;
          end
        end
      end
      DELAY: begin
        ovr = pri_edge;
        if (cnt_q == CNT_W'(PRE_DELAY - 1)) begin
          state_d = PLAY;
          n_d     = '0;
          addr_d  = ADDR_W'(wave_base(code_q));
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PLAY: begin
        ovr = pri_edge;
        rd  = 1'b1;
        if (n_q == len - 16'd1) begin
          state_d = FLUSH;
        end else begin
          n_d    = n_q + 16'd1;
          addr_d = addr_q + 1'b1;
        end
      end
      FLUSH: begin
        ovr     = pri_edge;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ram_rd   = rd;
  assign ram_addr = rd ? addr_q : '0;

  // RAM return capture: data is valid the cycle after the read.
  always_ff @(posedge clk_100M) begin
    if (!rst_n) begin
      rd_q    <= 1'b0;
      s_valid <= 1'b0;
      s_i     <= '0;
      s_q     <= '0;
    end else begin
      rd_q    <= rd;
      s_valid <= rd_q;
      s_i     <= rd_q ? ram_data[2*DATA_W-1:DATA_W] : '0;
      s_q     <= rd_q ? ram_data[DATA_W-1:0] : '0;
    end
  end

`ifdef DAC_TAPER_EN
  logic [6:0]  k_rd, k_q, s_k;
  logic [15:0] tail_start;

  assign tail_start = len - 16'(TAPER_LEN);

  // Ramp weight for the sample being read.
  always_comb begin
    k_rd = 7'(TAPER_LEN);
    if (n_q < 16'(TAPER_LEN))
      k_rd = 7'(n_q + 16'd1);
    else if (n_q >= tail_start)
      k_rd = 7'(len - n_q);
  end

  // Weight follows its sample down the read pipeline.
  always_ff @(posedge clk_100M) begin
    if (!rst_n) begin
      k_q <= '0;
      s_k <= '0;
    end else begin
      k_q <= k_rd;
      s_k <= k_q;
    end
  end

  dac_taper #(
    .DATA_W(DATA_W)
  ) u_taper (
    .clk      (clk_100M),
    .rst_n    (rst_n),
    .in_valid (s_valid),
    .in_k     (s_k),
    .in_i     (s_i),
    .in_q     (s_q),
    .out_valid(dac_valid),
    .out_i    (dac_i),
    .out_q    (dac_q)
  );

  assign busy = (state_q != IDLE) | rd_q | s_valid | dac_valid;
`else
  assign dac_valid = s_valid;
  assign dac_i     = s_i;
  assign dac_q     = s_q;
  assign busy      = (state_q != IDLE) | rd_q | dac_valid;
`endif

  assign tx_gate = dac_valid;

endmodule

// File: tb/tb_pri_dac_tx.sv
// Scoreboard bench for pri_dac_tx.
// Build with DAC_TAPER_EN to check the tapered variant.
module tb_pri_dac_tx;

  localparam int DW = 16;
  localparam int AW = 15;
  localparam int PD = 120;
`ifdef DAC_TAPER_EN
  localparam int LAT = PD + 4;
`else
  localparam int LAT = PD + 3;
`endif

  logic          clk_100M = 1'b0;
  logic          rst_n = 1'b0;
  logic          PRI = 1'b0;
  logic [7:0]    wave_code = 8'h00;
  logic [AW-1:0] ram_addr;
  logic          ram_rd;
  logic [2*DW-1:0] ram_data = '0;
  logic [DW-1:0] dac_i, dac_q;
  logic          dac_valid, tx_gate, busy;
  logic          err_code, err_overrun;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [31:0] sb[$];

  pri_dac_tx #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .PRE_DELAY(PD)
  ) dut (
    .clk_100M   (clk_100M),
    .rst_n      (rst_n),
    .PRI        (PRI),
    .wave_code  (wave_code),
    .ram_addr   (ram_addr),
    .ram_rd     (ram_rd),
    .ram_data   (ram_data),
    .dac_i      (dac_i),
    .dac_q      (dac_q),
    .dac_valid  (dac_valid),
    .tx_gate    (tx_gate),
    .busy       (busy),
    .err_code   (err_code),
    .err_overrun(err_overrun)
  );

  always #5 clk_100M = ~clk_100M;

  always @(posedge clk_100M) cyc <= cyc + 1;

  function automatic logic [15:0] ram_i(input logic [AW-1:0] a);
`ifdef DAC_TAPER_EN
    return 16'h4000;
`else
    return 16'({1'b0, a} * 3 + 16'h8001);
`endif
  endfunction

  function automatic logic [15:0] ram_q(input logic [AW-1:0] a);
`ifdef DAC_TAPER_EN
    return 16'h4000;
`else
    return ~{1'b0, a};
`endif
  endfunction

  always @(posedge clk_100M)
    ram_data <= ram_rd ? {ram_i(ram_addr), ram_q(ram_addr)} : 32'h0;

  function automatic int len_of(input logic [7:0] c);
    case (c)
      8'h01: return 500;
      8'h02: return 1300;
      8'h03: return 2000;
      8'h04: return 24000;
      8'h05: return 4000;
      8'h06: return 4000;
      8'h07: return 10000;
      default: return 0;
    endcase
  endfunction

  function automatic int base_of(input logic [7:0] c);
    case (c)
      8'h01: return 0;
      8'h02: return 512;
      8'h03: return 2048;
      8'h04: return 8768;
      8'h05: return 4096;
      8'h06: return 16384;
      8'h07: return 20480;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input int a, input int n, input int len);
    logic signed [15:0] si, sq;
    int k;
    si = ram_i(AW'(a));
    sq = ram_q(AW'(a));
    k  = 64;
    if (n < 64) k = n + 1;
    else if (n >= len - 64) k = len - n;
`ifdef DAC_TAPER_EN
    si = 16'((32'(si) * k) >>> 6);
    sq = 16'((32'(sq) * k) >>> 6);
`endif
    return {si, sq};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic burst(input logic [7:0] code, input int ovr_at, input int rst_at);
    int len, base, e, first, cnt, lastv, fall, ovp, maxa;
    bit cut;
    logic [31:0] w;
    len  = len_of(code);
    base = base_of(code);
    for (int n = 0; n < len; n++) sb.push_back(exp_word(base + n, n, len));
    @(negedge clk_100M);
    wave_code = code;
    PRI = 1'b1;
    e = cyc;
    @(negedge clk_100M);
    PRI = 1'b0;
    chk("busy_on", busy, 1);
    first = -1; cnt = 0; lastv = -1; fall = -1; ovp = 0; maxa = -1; cut = 0;
    for (int k = 0; k < len + PD + 20 && fall < 0 && !cut; k++) begin
      if (ram_rd && int'(ram_addr) > maxa) maxa = int'(ram_addr);
      if (dac_valid) begin
        if (first < 0) first = cyc;
        cnt++;
        lastv = cyc;
        if (sb.size() == 0) begin
          chk("extra", cnt, len);
        end else begin
          w = sb.pop_front();
          chk("dac_i", dac_i, w[31:16]);
          chk("dac_q", dac_q, w[15:0]);
          chk("gate", tx_gate, 1);
        end
      end
      if (first >= 0 && !busy && fall < 0) fall = cyc;
      case (ovp)
        0: if (ovr_at > 0 && cnt == ovr_at) begin
          PRI = 1'b1;
          wave_code = 8'h01;
          ovp = 1;
        end
        1: begin
          chk("ovr_pulse", err_overrun, 1);
          PRI = 1'b0;
          ovp = 2;
        end
        2: begin
          chk("ovr_clear", err_overrun, 0);
          ovp = 3;
        end
        default: ;
      endcase
      if (rst_at > 0 && cnt == rst_at) begin
        rst_n = 1'b0;
        @(negedge clk_100M);
        chk("rst_valid", dac_valid, 0);
        chk("rst_gate", tx_gate, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd", ram_rd, 0);
        chk("rst_di", dac_i, 0);
        chk("rst_dq", dac_q, 0);
        rst_n = 1'b1;
        cut = 1;
        sb.delete();
      end
      if (!cut) @(negedge clk_100M);
    end
    if (!cut) begin
      chk("latency", first - e, LAT);
      chk("count", cnt, len);
      chk("busy_fall", fall - lastv, 1);
      chk("max_addr", maxa, base + len - 1);
      chk("sb_left", sb.size(), 0);
    end
    sb.delete();
    repeat (3) @(negedge clk_100M);
  endtask

  initial begin
    bit any;
    repeat (3) @(negedge clk_100M);
    chk("rst_valid0", dac_valid, 0);
    chk("rst_gate0", tx_gate, 0);
    chk("rst_busy0", busy, 0);
    chk("rst_rd0", ram_rd, 0);
    chk("rst_addr0", ram_addr, 0);
    chk("rst_di0", dac_i, 0);
    chk("rst_errc0", err_code, 0);
    chk("rst_erro0", err_overrun, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_100M);

    burst(8'h01, 0, 0);
    burst(8'h04, 0, 0);

    @(negedge clk_100M);
    wave_code = 8'h2A;
    PRI = 1'b1;
    @(negedge clk_100M);
    PRI = 1'b0;
    chk("err_code_on", err_code, 1);
    chk("err_busy", busy, 0);
    @(negedge clk_100M);
    chk("err_code_off", err_code, 0);
    any = 0;
    repeat (PD + 10) begin
      @(negedge clk_100M);
      any |= busy | tx_gate | dac_valid;
    end
    chk("err_quiet", any, 0);

    burst(8'h07, 300, 0);
    burst(8'h03, 0, 200);
    burst(8'h03, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
